// File: rtl/pipe_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests, queues returned words for ID.
// Optional FETCH_PERF_EN adds a saturating bubble counter port (bubble_cnt_o).
module pipe_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        id_ready_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outst;
    logic [CW-1:0] discard;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    logic [CW-1:0] live_slots;
    logic [31:0]   redirect_pc_al;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;

    // Requests are admitted only while every live slot (queued or in flight) has a home.
    always_comb begin
        resp           = imem_rvalid_i && (outst != '0);
        live_slots     = count + outst - discard;
        imem_req_o     = rst_i && !redirect_i && (live_slots < DEPTH_C);
        imem_addr_o    = fetch_pc;
        grant          = imem_req_o && imem_gnt_i;
        push           = resp && (discard == '0) && !redirect_i;
        inst_valid_o   = (count != '0);
        pop            = inst_valid_o && id_ready_i && !redirect_i;
        inst_o         = inst_valid_o ? q_inst[head] : 32'h0;
        pc_o           = inst_valid_o ? q_pc[head]   : 32'h0;
        pc_plus4_o     = pc_o + 32'd4;
        redirect_pc_al = redirect_pc_i & ~32'h3;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            outst    <= '0;
            discard  <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect_i) begin
            // Everything still in flight after this edge belongs to the abandoned path.
            fetch_pc <= redirect_pc_al;
            resp_pc  <= redirect_pc_al;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            outst    <= outst - CW'(resp);
            discard  <= outst - CW'(resp);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outst <= outst + CW'(grant) - CW'(resp);
            if (resp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                tail    <= tail + AW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage; contents are masked on the outputs while empty, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_inst[tail] <= imem_rdata_i;
            q_pc[tail]   <= resp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    // Cycles where ID could have taken an instruction but none was available.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (id_ready_i && !inst_valid_o && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Self-checking bench for pipe_fetch_unit: queue-level reference model, randomized memory latency and redirects.
module tb_pipe_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        id_ready_i;
`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt_o;
`endif

    always #5 clk = ~clk;

    pipe_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .id_ready_i(id_ready_i)
`ifdef FETCH_PERF_EN
        , .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: delivered entries, in-flight requests (live or abandoned), next fetch address.
    typedef struct packed { logic live; logic [31:0] pc; } fl_t;
    typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
    logic [63:0] m_q[$];
    fl_t         m_fl[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_bubble;
    pend_t       mem_q[$];
    int          cyc = 0;
    int          fixed_lat = -1;
    int          grant_cnt = 0;

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_plus4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
    endfunction

    function automatic bit stale_any();
        foreach (mem_q[i]) if (mem_q[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_req(input bit redir);
        int live = 0;
        foreach (m_fl[i]) if (m_fl[i].live) live++;
        return !redir && ((m_q.size() + live) < DEPTH);
    endfunction

    task automatic step(input bit g, input bit rdy, input bit redir, input logic [31:0] rpc, input bit spur);
        bit          rv, er, g_eff, pop_now;
        logic [63:0] h;
        fl_t         fl;
        @(negedge clk);
        g_eff = g && !stale_any();
        rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        if (!rv && spur && (mem_q.size() == 0)) rv = 1'b1;
        imem_gnt_i    = g_eff;
        id_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_rvalid_i = rv;
        imem_rdata_i  = (rv && mem_q.size() != 0) ? mem_word(mem_q[0].addr) : $urandom;
        #1;
        er = exp_req(redir);
        obs_req = imem_req_o; obs_addr = imem_addr_o; obs_valid = inst_valid_o;
        obs_pc = pc_o; obs_plus4 = pc_plus4_o;
        chk("req", {31'b0, imem_req_o}, {31'b0, er});
        if (er) chk("addr", imem_addr_o, m_fetch_pc);
        if (m_q.size() != 0) begin
            h = m_q[0];
            chk("valid", {31'b0, inst_valid_o}, 32'd1);
            chk("pc", pc_o, h[63:32]);
            chk("inst", inst_o, h[31:0]);
            chk("pc_plus4", pc_plus4_o, h[63:32] + 32'd4);
        end else begin
            chk("valid", {31'b0, inst_valid_o}, 32'd0);
            chk("pc_empty", pc_o, 32'd0);
            chk("inst_empty", inst_o, 32'd0);
            chk("pc_plus4_empty", pc_plus4_o, 32'd4);
        end
`ifdef FETCH_PERF_EN
        chk("bubble", bubble_cnt_o, m_bubble);
`endif
        @(posedge clk);
        cyc++;
        if (rdy && (m_q.size() == 0) && (m_bubble != 32'hFFFF_FFFF)) m_bubble++;
        pop_now = !redir && (m_q.size() != 0) && rdy;
        if (pop_now) void'(m_q.pop_front());
        if (rv && mem_q.size() != 0) void'(mem_q.pop_front());
        if (rv && m_fl.size() != 0) begin
            fl = m_fl.pop_front();
            if (fl.live && !redir) m_q.push_back({fl.pc, mem_word(fl.pc)});
        end
        if (redir) begin
            m_q.delete();
            foreach (m_fl[i]) m_fl[i].live = 1'b0;
            m_fetch_pc = rpc & ~32'h3;
        end else if (er && g_eff) begin
            m_fl.push_back('{live: 1'b1, pc: m_fetch_pc});
            mem_q.push_back('{addr: m_fetch_pc,
                              due: cyc + ((fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2))),
                              stale: 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd4;
            grant_cnt++;
        end
    endtask

    task automatic rnd_step();
        logic [31:0] rpc;
        rpc = $urandom;
        if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 4, rpc, $urandom_range(0, 9) == 0);
    endtask

    // Asynchronous reset; mid = assert between clock edges while traffic is in flight.
    task automatic do_reset(input bit mid);
        @(negedge clk);
        if (mid) #2;
        rst_i = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_plus4", pc_plus4_o, 32'd4);
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0; redirect_i = 1'b0; id_ready_i = 1'b0;
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        m_q.delete(); m_fl.delete();
        m_fetch_pc = RESET_PC;
        m_bubble   = 32'd0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
            #1 chk("rst_hold_req", {31'b0, imem_req_o}, 32'd0);
        end
        rst_i = 1'b1;
    endtask

    initial begin
        bit found;
        rst_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b0;
        m_fetch_pc = RESET_PC; m_bubble = 32'd0;
        do_reset(1'b0);

        // Idle with ID ready counts bubbles.
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
        #1 chk("bubble_three", bubble_cnt_o, 32'd3);
`endif

        // Streaming with single-cycle memory.
        do_reset(1'b0);
        fixed_lat = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t1_addr0", obs_addr, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t1_no_bypass", {31'b0, obs_valid}, 32'd0);
        chk("t1_addr1", obs_addr, 32'h4);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t1_first_pc", obs_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t1_second_pc", obs_pc, 32'h4);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Stalled ID fills the queue, then drains and fetch resumes.
        do_reset(1'b0);
        grant_cnt = 0;
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_grants", grant_cnt, 32'd4);
        chk("t2_req_off", {31'b0, obs_req}, 32'd0);
        chk("t2_head_pc", obs_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t2_still_off", {31'b0, obs_req}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t2_resume_req", {31'b0, obs_req}, 32'd1);
        chk("t2_resume_addr", obs_addr, 32'h10);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect with two requests outstanding.
        do_reset(1'b0);
        fixed_lat = 4;
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
        fixed_lat = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_addr", obs_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (obs_valid) begin
                found = 1'b1;
                chk("t3_first_pc", obs_pc, 32'h100);
            end
        end
        if (!found) chk("t3_timeout", 32'd0, 32'd1);

        // Redirect coinciding with a response and a pop while two entries are queued.
        do_reset(1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_flushed", {31'b0, obs_valid}, 32'd0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Address wrap at 2^32, low redirect bits ignored.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_addr0", obs_addr, 32'hFFFF_FFF8);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_addr1", obs_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_addr2", obs_addr, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (obs_valid && obs_pc == 32'hFFFF_FFFC) begin
                found = 1'b1;
                chk("t5_plus4_wrap", obs_plus4, 32'h0);
            end
        end
        if (!found) chk("t5_timeout", 32'd0, 32'd1);

        // Mid-stream reset with responses still pending; stale ones must be ignored.
        fixed_lat = 2;
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        do_reset(1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
        #1 chk("t6_bubble", bubble_cnt_o, 32'd3);
`endif
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (obs_req && imem_gnt_i) begin
                found = 1'b1;
                chk("t6_restart_addr", obs_addr, RESET_PC);
            end
        end
        if (!found) chk("t6_timeout", 32'd0, 32'd1);

        // Randomized traffic with occasional asynchronous resets.
        fixed_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset(1'b1);
            rnd_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
